// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter in front of a shared FIFO write port.
// Tracks FIFO occupancy from its own write strobe and the consumer's read strobe.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int DEPTH    = 10,
  parameter int MAXBURST = 4,
  parameter int CW       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_rd,
  output logic               fifo_wr,
  output logic [DW-1:0]      fifo_din,
  output logic [NREQ-1:0]    grant,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = 4;

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] gidx_last_q, gidx_last_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          owner_valid;
  logic          rd_eff;

  assign count  = count_q;
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign rd_eff = fifo_rd & ~empty;

  // Scan downwards so the nearest index after gidx_last wins (last assignment).
  always_comb begin
    scan_idx   = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      scan_idx = IW'((int'(gidx_last_q) + k) % NREQ);
      if (req_valid[scan_idx]) begin
        pick_idx   = scan_idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    gidx_last_d = gidx_last_q;
    bcnt_d      = bcnt_q;
    grant       = '0;
    req_ready   = '0;
    fifo_wr     = 1'b0;
    fifo_din    = '0;
    owner_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          bcnt_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        for (int i = 0; i < NREQ; i++) begin
          if (gidx_q == IW'(i)) begin
            grant[i]     = 1'b1;
            req_ready[i] = ~full;
            owner_valid  = req_valid[i];
            fifo_din     = req_data[i*DW +: DW];
          end
        end
        fifo_wr = owner_valid & ~full;
        if (!owner_valid) begin
          state_d     = IDLE;
          gidx_last_d = gidx_q;
        end else if (fifo_wr) begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_d == BW'(MAXBURST)) begin
            state_d     = IDLE;
            gidx_last_d = gidx_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write is gated by full alone, so a read in a full cycle only helps next cycle.
  always_comb begin
    count_d = count_q;
    if (fifo_wr && !rd_eff) begin
      count_d = count_q + 1'b1;
    end else if (!fifo_wr && rd_eff) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gidx_q      <= '0;
      gidx_last_q <= IW'(NREQ - 1);
      bcnt_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      gidx_last_q <= gidx_last_d;
      bcnt_q      <= bcnt_d;
      count_q     <= count_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, directed corner sequences and a randomized run
// against a cycle-level reference model of the arbiter.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DW = 8, DEPTH = 10, MAXBURST = 4, CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_data  = '0;
  logic               fifo_rd   = 1'b0;
  logic [NREQ-1:0]    req_ready, grant;
  logic               fifo_wr, full, empty;
  logic [DW-1:0]      fifo_din;
  logic [CW-1:0]      count;

  int tests = 0;
  int fails = 0;

  // reference model: owner index (-1 when nobody owns the port), previous owner,
  // writes in the current burst, and FIFO occupancy
  int m_owner, m_last, m_nwr, m_occ;
  logic [NREQ-1:0] e_grant, e_ready;
  logic            e_wr;
  logic [DW-1:0]   e_din;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [DW-1:0]   d0;
    logic            rd;
    logic [NREQ-1:0] grant;
    logic            wr;
    logic [DW-1:0]   din;
    logic [CW-1:0]   count;
  } vec_t;
  vec_t tbl[$];

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .MAXBURST(MAXBURST), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_rd(fifo_rd), .fifo_wr(fifo_wr), .fifo_din(fifo_din), .grant(grant),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_nwr   = 0;
    m_occ   = 0;
  endtask

  task automatic model_outputs();
    e_grant = '0;
    e_ready = '0;
    e_wr    = 1'b0;
    e_din   = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      if (m_occ < DEPTH) e_ready[m_owner] = 1'b1;
      e_wr  = req_valid[m_owner] && (m_occ < DEPTH);
      e_din = req_data[m_owner*DW +: DW];
    end
  endtask

  task automatic model_advance();
    int rd_ok;
    rd_ok = (fifo_rd && m_occ > 0) ? 1 : 0;
    m_occ = m_occ + (e_wr ? 1 : 0) - rd_ok;
    if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (m_owner < 0 && req_valid[(m_last + k) % NREQ]) begin
          m_owner = (m_last + k) % NREQ;
          m_nwr   = 0;
        end
      end
    end else if (!req_valid[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (e_wr) begin
      m_nwr++;
      if (m_nwr == MAXBURST) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  // One clock: compare against the model, advance it, then refresh accepted data.
  task automatic cycle();
    logic [NREQ-1:0] acc;
    #2;
    model_outputs();
    chk("grant", grant, e_grant);
    chk("req_ready", req_ready, e_ready);
    chk("fifo_wr", fifo_wr, e_wr);
    if (e_wr) chk("fifo_din", fifo_din, e_din);
    chk("count", count, m_occ);
    chk("full", full, (m_occ == DEPTH) ? 1 : 0);
    chk("empty", empty, (m_occ == 0) ? 1 : 0);
    acc = req_valid & e_ready;
    model_advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) req_data[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    fifo_rd   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst grant", grant, 0);
    chk("rst ready", req_ready, 0);
    chk("rst fifo_wr", fifo_wr, 0);
    chk("rst fifo_din", fifo_din, 0);
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    rst = 1'b0;
  endtask

  task automatic add_vec(input logic [NREQ-1:0] v, input logic [DW-1:0] d, input logic r,
                         input logic [NREQ-1:0] g, input logic w, input logic [DW-1:0] o,
                         input logic [CW-1:0] c);
    vec_t t;
    t.valid = v; t.d0 = d; t.rd = r; t.grant = g; t.wr = w; t.din = o; t.count = c;
    tbl.push_back(t);
  endtask

  initial begin
    int n, mc;
    logic [NREQ-1:0] prev_g;
    logic [NREQ-1:0] seq[$];
    logic [NREQ-1:0] rr_exp[5];

    // single producer, six words: 4-word burst, bubble, 2 more, then reads
    add_vec(4'h1, 8'h11, 0, 4'h0, 0, 8'h00, 4'd0);
    add_vec(4'h1, 8'h11, 0, 4'h1, 1, 8'h11, 4'd0);
    add_vec(4'h1, 8'h12, 0, 4'h1, 1, 8'h12, 4'd1);
    add_vec(4'h1, 8'h13, 0, 4'h1, 1, 8'h13, 4'd2);
    add_vec(4'h1, 8'h14, 0, 4'h1, 1, 8'h14, 4'd3);
    add_vec(4'h1, 8'h15, 0, 4'h0, 0, 8'h00, 4'd4);
    add_vec(4'h1, 8'h15, 0, 4'h1, 1, 8'h15, 4'd4);
    add_vec(4'h1, 8'h16, 0, 4'h1, 1, 8'h16, 4'd5);
    add_vec(4'h0, 8'h00, 0, 4'h1, 0, 8'h00, 4'd6);
    add_vec(4'h0, 8'h00, 1, 4'h0, 0, 8'h00, 4'd6);
    add_vec(4'h0, 8'h00, 1, 4'h0, 0, 8'h00, 4'd5);

    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      req_valid = tbl[r].valid;
      req_data  = '0;
      req_data[DW-1:0] = tbl[r].d0;
      fifo_rd   = tbl[r].rd;
      #2;
      chk($sformatf("vec%0d grant", r), grant, tbl[r].grant);
      chk($sformatf("vec%0d fifo_wr", r), fifo_wr, tbl[r].wr);
      if (tbl[r].wr) chk($sformatf("vec%0d fifo_din", r), fifo_din, tbl[r].din);
      chk($sformatf("vec%0d count", r), count, tbl[r].count);
      @(posedge clk);
      #1;
    end

    // round robin with continuous reads
    do_reset();
    req_valid = 4'hF;
    fifo_rd   = 1'b1;
    prev_g    = '0;
    mc        = 0;
    for (int c = 0; c < 25; c++) begin
      if (grant != 0 && prev_g == 0) seq.push_back(grant);
      prev_g = grant;
      if (int'(count) > mc) mc = int'(count);
      cycle();
    end
    rr_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    chk("rr burst count", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk($sformatf("rr order %0d", i), seq[i], rr_exp[i]);
    chk("rr count<=1", (mc <= 1) ? 1 : 0, 1);

    // full stall and full boundary
    do_reset();
    req_valid = 4'b0100;
    n = 0;
    while (count != CW'(DEPTH) && n < 40) begin
      cycle();
      n++;
    end
    chk("stall count", count, 10);
    chk("stall full", full, 1);
    chk("stall ready", req_ready, 0);
    chk("stall grant", grant, 4'b0100);
    cycle();
    cycle();
    chk("stall grant held", grant, 4'b0100);
    fifo_rd = 1'b1;
    #1;
    chk("full boundary wr", fifo_wr, 0);
    cycle();
    fifo_rd = 1'b0;
    chk("stall after read count", count, 9);
    chk("stall resume wr", fifo_wr, 1);
    cycle();
    chk("stall refill count", count, 10);

    // early release: producer 1 gives 2 words, then producer 2 preferred over 0
    do_reset();
    req_valid = 4'b0010;
    cycle();
    cycle();
    cycle();
    req_valid = 4'b0101;
    chk("release grant before drop", grant, 4'b0010);
    cycle();
    chk("release idle", grant, 0);
    chk("release count", count, 2);
    cycle();
    chk("release next owner", grant, 4'b0100);

    // empty read ignored; simultaneous write+read at count 5
    do_reset();
    fifo_rd = 1'b1;
    cycle();
    chk("empty read count", count, 0);
    chk("empty read empty", empty, 1);
    fifo_rd   = 1'b0;
    req_valid = 4'b0001;
    for (int c = 0; c < 7; c++) cycle();
    fifo_rd = 1'b1;
    #1;
    chk("simul pre count", count, 5);
    chk("simul wr", fifo_wr, 1);
    cycle();
    fifo_rd = 1'b0;
    chk("simul post count", count, 5);

    // reset mid-burst at count 7, then 0 beats 3 in the tie
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 9; c++) cycle();
    chk("midrst pre count", count, 7);
    chk("midrst pre grant", grant, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst grant", grant, 0);
    chk("midrst fifo_wr", fifo_wr, 0);
    chk("midrst ready", req_ready, 0);
    chk("midrst count", count, 0);
    chk("midrst empty", empty, 1);
    model_reset();
    req_valid = 4'b1001;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    chk("midrst tie winner", grant, 4'b0001);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom_range(0, 9) < 7);
      fifo_rd = ($urandom_range(0, 99) < 45);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
